// File: rtl/hamming_enc_seq_pkg.sv
// rtl/hamming_enc_seq_pkg.sv - shared ALU op codes, Hamming masks and sequencer types
package hamming_enc_seq_pkg;

    localparam int NSTEPS = 23;

    localparam logic [2:0] kNOP  = 3'd0;
    localparam logic [2:0] kAND  = 3'd1;
    localparam logic [2:0] kBXOR = 3'd3;
    localparam logic [2:0] bRXOR = 3'd5;

    // Index 0..3 selects p1, p2, p4, p8; LO holds d7..d0, HI holds d10..d8.
    localparam logic [7:0] HAM_MLO [4] = '{8'h5B, 8'h6D, 8'h8E, 8'hF0};
    localparam logic [2:0] HAM_MHI [4] = '{3'b101, 3'b110, 3'b111, 3'b111};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;
    typedef enum logic [1:0] {A_LO, A_HI, A_T, A_U} a_sel_t;
    typedef enum logic [2:0] {B_MLO, B_MHI, B_T, B_U, B_P, B_ZERO, B_HI} b_sel_t;
    typedef enum logic [1:0] {D_T, D_U, D_P} dst_t;

    typedef struct packed {
        logic [2:0] cmd;
        a_sel_t     a_sel;
        b_sel_t     b_sel;
        dst_t       dst;
        logic [2:0] pidx;
    } step_ctl_t;

    // p holds {p0, p8, p4, p2, p1}; result bit i is codeword position i.
    function automatic logic [15:0] ham_assemble(logic [7:0] lo, logic [2:0] hi, logic [4:0] p);
        return {hi, lo[7:4], p[3], lo[3:1], p[2], lo[0], p[1], p[0], p[4]};
    endfunction

endpackage

// File: rtl/hamming_enc_seq_if.sv
// rtl/hamming_enc_seq_if.sv - request/grant bus between the encoder and the shared ALU
interface hamming_enc_seq_if;
    logic       alu_req;
    logic       alu_gnt;
    logic [2:0] alu_cmd;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_rslt;

    modport master (output alu_req, alu_cmd, alu_a, alu_b, input alu_gnt, alu_rslt);
    modport slave  (input alu_req, alu_cmd, alu_a, alu_b, output alu_gnt, alu_rslt);
endinterface

// File: rtl/hamming_step_rom.sv
// rtl/hamming_step_rom.sv - micro-step decode: step index to ALU op, operand selects and destination
module hamming_step_rom
    import hamming_enc_seq_pkg::*;
(
    input  logic [4:0] i_step,
    output step_ctl_t  o_ctl
);

    logic [1:0] w_k;
    logic [4:0] w_base;
    logic [4:0] w_r;

    always_comb begin
        o_ctl.cmd   = kNOP;
        o_ctl.a_sel = A_LO;
        o_ctl.b_sel = B_ZERO;
        o_ctl.dst   = D_T;
        o_ctl.pidx  = 3'd0;

        if (i_step >= 5'd15)      w_k = 2'd3;
        else if (i_step >= 5'd10) w_k = 2'd2;
        else if (i_step >= 5'd5)  w_k = 2'd1;
        else                      w_k = 2'd0;
        w_base = {1'b0, w_k, 2'b00} + {3'b000, w_k};
        w_r    = i_step - w_base;

        // Steps 0..19: five steps per Hamming parity, 20..22: overall parity.
        if (i_step < 5'd20) begin
            o_ctl.pidx = {1'b0, w_k};
            case (w_r)
                5'd0: begin o_ctl.cmd = kAND;  o_ctl.a_sel = A_LO; o_ctl.b_sel = B_MLO;  o_ctl.dst = D_T; end
                5'd1: begin o_ctl.cmd = bRXOR; o_ctl.a_sel = A_T;  o_ctl.b_sel = B_ZERO; o_ctl.dst = D_T; end
                5'd2: begin o_ctl.cmd = kAND;  o_ctl.a_sel = A_HI; o_ctl.b_sel = B_MHI;  o_ctl.dst = D_U; end
                5'd3: begin o_ctl.cmd = bRXOR; o_ctl.a_sel = A_U;  o_ctl.b_sel = B_ZERO; o_ctl.dst = D_U; end
                5'd4: begin o_ctl.cmd = kBXOR; o_ctl.a_sel = A_T;  o_ctl.b_sel = B_U;    o_ctl.dst = D_P; end
                default: ;
            endcase
        end else begin
            case (i_step)
                5'd20: begin o_ctl.cmd = kBXOR; o_ctl.a_sel = A_LO; o_ctl.b_sel = B_HI; o_ctl.dst = D_T; end
                5'd21: begin o_ctl.cmd = kBXOR; o_ctl.a_sel = A_T;  o_ctl.b_sel = B_P;  o_ctl.dst = D_T; end
                5'd22: begin
                    o_ctl.cmd   = bRXOR;
                    o_ctl.a_sel = A_T;
                    o_ctl.b_sel = B_ZERO;
                    o_ctl.dst   = D_P;
                    o_ctl.pidx  = 3'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hamming_enc_seq.sv
// rtl/hamming_enc_seq.sv - SECDED Hamming(15,11)+parity encoder sequenced over a shared 8-bit ALU
module hamming_enc_seq
    import hamming_enc_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [10:0]               data_in,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               code_out,
    hamming_enc_seq_if.master         alu
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;
    logic [4:0]  r_step;
    logic [7:0]  r_lo;
    logic [2:0]  r_hi;
    logic [7:0]  r_t;
    logic [7:0]  r_u;
    logic [4:0]  r_p;
    logic [15:0] r_code;

    step_ctl_t   w_ctl;
    logic [7:0]  w_a;
    logic [7:0]  w_b;
    logic [4:0]  w_p_nxt;
    logic        w_run;
    logic        w_accept;
    logic        w_fire;
    logic        w_last;

    hamming_step_rom u_rom (
        .i_step (r_step),
        .o_ctl  (w_ctl)
    );

    assign w_run    = (r_state == S_RUN);
    assign w_accept = start && (r_state != S_RUN);
    assign w_fire   = w_run && alu.alu_gnt;
    assign w_last   = w_fire && (r_step == 5'(NSTEPS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_a = 8'h00;
        case (w_ctl.a_sel)
            A_LO:    w_a = r_lo;
            A_HI:    w_a = {5'b0, r_hi};
            A_T:     w_a = r_t;
            A_U:     w_a = r_u;
            default: w_a = 8'h00;
        endcase
    end

    always_comb begin
        w_b = 8'h00;
        case (w_ctl.b_sel)
            B_MLO:   w_b = HAM_MLO[w_ctl.pidx[1:0]];
            B_MHI:   w_b = {5'b0, HAM_MHI[w_ctl.pidx[1:0]]};
            B_HI:    w_b = {5'b0, r_hi};
            B_T:     w_b = r_t;
            B_U:     w_b = r_u;
            B_P:     w_b = {4'b0, r_p[3:0]};
            default: w_b = 8'h00;
        endcase
    end

    // Next P value is formed here so the final step can assemble the codeword in the same edge.
    always_comb begin
        w_p_nxt = r_p;
        if (w_ctl.dst == D_P) begin
            for (int i = 0; i < 5; i++) begin
                if (w_ctl.pidx == 3'(i)) w_p_nxt[i] = alu.alu_rslt[0];
            end
        end
    end

    assign alu.alu_req = w_run;
    assign alu.alu_cmd = w_run ? w_ctl.cmd : 3'd0;
    assign alu.alu_a   = w_run ? w_a : 8'h00;
    assign alu.alu_b   = w_run ? w_b : 8'h00;

    assign busy     = w_run;
    assign done     = (r_state == S_DONE);
    assign code_out = r_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 5'd0;
            r_lo    <= 8'h00;
            r_hi    <= 3'd0;
            r_t     <= 8'h00;
            r_u     <= 8'h00;
            r_p     <= 5'd0;
            r_code  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_lo   <= data_in[7:0];
                r_hi   <= data_in[10:8];
                r_step <= 5'd0;
            end else if (w_fire) begin
                r_step <= r_step + 5'd1;
                case (w_ctl.dst)
                    D_T:     r_t <= alu.alu_rslt;
                    D_U:     r_u <= alu.alu_rslt;
                    D_P:     r_p <= w_p_nxt;
                    default: ;
                endcase
                if (w_last) r_code <= ham_assemble(r_lo, r_hi, w_p_nxt);
            end
        end
    end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// tb/tb_hamming_enc_seq.sv - self-checking bench for hamming_enc_seq with an external ALU model
module tb_hamming_enc_seq;
    import hamming_enc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] data_in = 11'h000;
    logic        busy;
    logic        done;
    logic [15:0] code_out;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    hamming_enc_seq_if bus ();

    hamming_enc_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .code_out (code_out),
        .alu      (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_cmd)
            kAND:    bus.alu_rslt = bus.alu_a & bus.alu_b;
            kBXOR:   bus.alu_rslt = bus.alu_a ^ bus.alu_b;
            bRXOR:   bus.alu_rslt = {7'b0, ^bus.alu_a};
            default: bus.alu_rslt = 8'h00;
        endcase
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Textbook placement: data fills non-power-of-two positions, parity at 2^k, p0 makes the word even.
    function automatic logic [15:0] ref_code(logic [10:0] d);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) par ^= c[pos];
            c[1 << k] = par;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [4:0] syndrome(logic [15:0] c);
        logic [3:0] s;
        s = 4'd0;
        for (int pos = 1; pos < 16; pos++) if (c[pos]) s ^= 4'(pos);
        return {s, ^c};
    endfunction

    function automatic bit secded_ok(logic [15:0] c);
        bit seen [32];
        bit ok;
        logic [4:0] s;
        logic [15:0] flip;
        ok = (syndrome(c) == 5'd0);
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            flip = 16'h0001 << i;
            s = syndrome(c ^ flip);
            if (s == 5'd0 || seen[s]) ok = 1'b0;
            seen[s] = 1'b1;
        end
        return ok;
    endfunction

    // Caller is just past a negedge; start is raised immediately so a DONE cycle gives back-to-back.
    task automatic run_encode(input logic [10:0] d, input int sa, input int sb, input int slen,
                              input bit rnd, input int inj_cyc, input logic [10:0] inj_d,
                              output logic [15:0] code, output int lat, output int nbusy,
                              output int nstall, output bit stable);
        int g;
        int ks;
        bit pg;
        logic [18:0] prev;
        g = 0; ks = 0; pg = 1'b1; prev = '0;
        lat = 0; nbusy = 0; nstall = 0; stable = 1'b1;
        start = 1'b1;
        data_in = d;
        bus.alu_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 200) begin
            if (busy) nbusy++;
            if (lat == inj_cyc) begin
                start = 1'b1;
                data_in = inj_d;
            end else begin
                start = 1'b0;
            end
            if (!pg && {bus.alu_cmd, bus.alu_a, bus.alu_b} !== prev) stable = 1'b0;
            prev = {bus.alu_cmd, bus.alu_a, bus.alu_b};
            if (rnd) bus.alu_gnt = ($urandom_range(0, 3) != 0);
            else     bus.alu_gnt = !((g == sa || g == sb) && ks < slen);
            if (bus.alu_gnt) begin g++; ks = 0; end
            else begin ks++; nstall++; end
            pg = bus.alu_gnt;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        bus.alu_gnt = 1'b1;
        if (!done) $display("FAIL timeout: no done within %0d cycles for data %0h", lat, d);
        chk("done_seen", done, 1'b1);
        chk("idle_bus_in_done", {busy, bus.alu_req, bus.alu_cmd, bus.alu_a, bus.alu_b}, 0);
        code = code_out;
    endtask

    typedef struct {
        logic [10:0] d;
        logic [15:0] code;
        int          sa;
        int          sb;
        int          slen;
        int          lat;
    } vec_t;

    vec_t        vt [5];
    logic [15:0] code;
    int          lat, nbusy, nstall, dc0;
    bit          stable;
    logic [10:0] rd;

    initial begin
        vt[0] = '{11'h000, 16'h0000, -1, -1, 0, 23};
        vt[1] = '{11'h7FF, 16'hFFFF, -1, -1, 0, 23};
        vt[2] = '{11'h001, 16'h000F, -1, -1, 0, 23};
        vt[3] = '{11'h400, 16'h8117, -1, -1, 0, 23};
        vt[4] = '{11'h400, 16'h8117,  3, 10, 3, 29};

        bus.alu_gnt = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, code_out, bus.alu_req, bus.alu_cmd, bus.alu_a, bus.alu_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_encode(vt[i].d, vt[i].sa, vt[i].sb, vt[i].slen, 1'b0, -1, 11'h000,
                       code, lat, nbusy, nstall, stable);
            chk($sformatf("vec%0d_code", i), code, vt[i].code);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), nbusy, vt[i].lat);
            chk($sformatf("vec%0d_stall_stable", i), stable, 1'b1);
            repeat (2) @(negedge clk);
        end

        // Abort at step 12 of 11'h7FF via reset, then a clean encode.
        start = 1'b1; data_in = 11'h7FF; bus.alu_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_reset_state", {busy, done, code_out, bus.alu_req, bus.alu_cmd, bus.alu_a, bus.alu_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        run_encode(11'h001, -1, -1, 0, 1'b0, -1, 11'h000, code, lat, nbusy, nstall, stable);
        chk("after_abort_code", code, 16'h000F);
        repeat (2) @(negedge clk);

        run_encode(11'h400, -1, -1, 0, 1'b0, 5, 11'h7FF, code, lat, nbusy, nstall, stable);
        chk("start_in_run_code", code, 16'h8117);
        chk("start_in_run_latency", lat, 23);
        repeat (2) @(negedge clk);

        dc0 = done_cnt;
        run_encode(11'h400, -1, -1, 0, 1'b0, -1, 11'h000, code, lat, nbusy, nstall, stable);
        chk("b2b_first_code", code, 16'h8117);
        run_encode(11'h001, -1, -1, 0, 1'b0, -1, 11'h000, code, lat, nbusy, nstall, stable);
        chk("b2b_second_code", code, 16'h000F);
        chk("b2b_done_gap", lat + 1, 24);
        repeat (2) @(negedge clk);
        chk("b2b_done_pulses", done_cnt - dc0, 2);

        for (int i = 0; i < 1000; i++) begin
            rd = 11'($urandom);
            run_encode(rd, -1, -1, 0, 1'b1, -1, 11'h000, code, lat, nbusy, nstall, stable);
            chk("rand_code", code, ref_code(rd));
            chk("rand_latency", lat, 23 + nstall);
            chk("rand_secded", secded_ok(code), 1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
